rmssd_seq_ctrl: RTL and testbench
=================================

// Module: rmssd_seq_ctrl
// PURPOSE
//   Sequencer for the rmssd_serial core. Accepts parallel 8-bit RR intervals on a valid/ready port.
//   Clears the core, serialises RR_COUNT bytes into its bit_in/bit_valid/rr_valid protocol (MSB first),
//   waits for done with a timeout, and returns the RMSSD result with a one-cycle valid pulse.
// PARAMETERS
//   RR_COUNT        8    RR bytes per measurement; must equal the core's RR_COUNT
//   CLR_CYCLES      2    cycles core_rst_n is held low before a measurement (>=1)
//   TIMEOUT_CYCLES  64   WAIT_DONE cycles before err_timeout (>=1)
//   RR_MIN          20   lowest accepted RR byte (only with RMSSD_RANGE_CHECK_EN)
//   RR_MAX          250  highest accepted RR byte (only with RMSSD_RANGE_CHECK_EN)
// PORTS
//   clk            in   1  clock
//   rst_n          in   1  asynchronous active-low reset
//   start          in   1  begin measurement (sampled in IDLE only)
//   abort          in   1  cancel measurement, any state
//   rr_in_valid    in   1  RR byte valid
//   rr_in_data     in   8  RR interval
//   rr_in_ready    out  1  controller can take a byte
//   core_rst_n     out  1  reset to the core (registered)
//   core_bit       out  1  serial data to the core bit_in
//   core_bit_valid out  1  to the core bit_valid
//   core_rr_valid  out  1  to the core rr_valid
//   core_rmssd     in   8  core rmssd_out
//   core_done      in   1  core done
//   result         out  8  last captured RMSSD
//   result_valid   out  1  1-cycle pulse when result updates
//   busy           out  1  state != IDLE
//   err_timeout    out  1  sticky; core did not finish in time
//   rr_range_err   out  1  sticky; out-of-range byte dropped (0 without the macro)
// BEHAVIOUR
//   Reset: state=IDLE; core_rst_n=0; result=0; result_valid=0; err_timeout=0; rr_range_err=0.
//   Reset also clears counters and the shift register.
//   States: IDLE -> CLEAR -> LOAD <-> SHIFT -> WAIT_DONE -> IDLE.
//   IDLE: core_rst_n=0. On start: clear err_timeout and rr_range_err, rr_sent=0, go to CLEAR.
//   CLEAR: core_rst_n=0 for exactly CLR_CYCLES cycles. core_rst_n rises on the cycle LOAD is entered.
//   LOAD: rr_in_ready=1 (decoded from state). On valid&&ready: latch the byte into sh[7:0], bit_idx=7, go to SHIFT.
//   SHIFT: lasts 8 cycles; core_bit_valid=1 and core_bit=sh[7]; sh shifts left every cycle.
//     core_rr_valid=1 only in the bit_idx==0 cycle, together with the last bit.
//     After bit 0: rr_sent++. If rr_sent==RR_COUNT go to WAIT_DONE, else go to LOAD.
//   Throughput: 9 cycles per byte with a back-to-back source (1 LOAD + 8 SHIFT).
//   Core strobes are 0 in every other state. Missing rr_in_valid stalls in LOAD; no bits are emitted.
//   WAIT_DONE: timer counts from 0.
//     core_done=1: result<=core_rmssd; result_valid pulses on the next cycle; go to IDLE.
//     Timer reaches TIMEOUT_CYCLES-1 with no done: err_timeout=1, result unchanged, no pulse, go to IDLE.
//     done and timeout in the same cycle: done wins.
//   core_done is ignored outside WAIT_DONE. A stale done is impossible because CLEAR resets the core.
//   abort: any state -> IDLE next cycle; core_rst_n=0 next cycle; partial byte discarded.
//     No result_valid, no error flag. abort beats start and core_done in the same cycle.
//   start while busy is ignored. Async reset mid-measurement returns every output to its reset value.
//   result holds its value until the next successful capture.
// CONFIGURATION
//   RMSSD_RANGE_CHECK_EN defined: a LOAD handshake with rr_in_data<RR_MIN or >RR_MAX consumes the byte.
//     The byte is not shifted, rr_sent is unchanged, rr_range_err=1, state stays LOAD.
//   Undefined: every byte is forwarded; rr_range_err is tied to 0; RR_MIN and RR_MAX are unused.
// TESTING
//   Real core, 8x RR=100, valid held high -> 72 SHIFT/LOAD cycles, result=0, result_valid one pulse, errs 0.
//   First byte 0xA5 -> core_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles; core_rr_valid only on the 8th.
//   rr_in_valid low 5 cycles between bytes 3 and 4 -> rr_in_ready high throughout; no core strobes; 8 bytes total.
//   Stubbed core, done never asserts, TIMEOUT_CYCLES=64 -> IDLE 64 cycles after WAIT_DONE; err_timeout=1; no pulse.
//   abort during bit 3 of byte 2 -> busy=0 and core_rst_n=0 next cycle; new start completes with correct result.
//   RMSSD_RANGE_CHECK_EN, byte 5 = 10 -> dropped, rr_range_err=1, a 9th in-range byte is needed, result correct.

Source files
------------

// File: rtl/rmssd_seq_ctrl.sv
// Sequencer for the rmssd_serial core: clears the core, serialises RR bytes MSB first, waits for done.
// Optional input range filter enabled by defining RMSSD_RANGE_CHECK_EN.
module rmssd_seq_ctrl #(
    parameter int RR_COUNT       = 8,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RR_MIN         = 20,
    parameter int RR_MAX         = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       rr_in_valid,
    input  logic [7:0] rr_in_data,
    output logic       rr_in_ready,
    output logic       core_rst_n,
    output logic       core_bit,
    output logic       core_bit_valid,
    output logic       core_rr_valid,
    input  logic [7:0] core_rmssd,
    input  logic       core_done,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       err_timeout,
    output logic       rr_range_err
);
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int NW = $clog2(RR_COUNT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_SHIFT, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [NW-1:0] rr_sent_q, rr_sent_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          err_timeout_q, err_timeout_d;
    logic          range_err_q, range_err_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          rr_ok;

`ifdef RMSSD_RANGE_CHECK_EN
    assign rr_ok        = (rr_in_data >= RR_MIN[7:0]) && (rr_in_data <= RR_MAX[7:0]);
    assign rr_range_err = range_err_q;
`else
    logic [16:0] unused_range;
    assign rr_ok        = 1'b1;
    assign rr_range_err = 1'b0;
    assign unused_range = {RR_MIN[7:0], RR_MAX[7:0], range_err_q};
`endif

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        timer_d        = timer_q;
        rr_sent_d      = rr_sent_q;
        sh_d           = sh_q;
        bit_idx_d      = bit_idx_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_timeout_d  = err_timeout_q;
        range_err_d    = range_err_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    err_timeout_d = 1'b0;
                    range_err_d   = 1'b0;
                    rr_sent_d     = '0;
                    clr_cnt_d     = '0;
                    state_d       = S_CLEAR;
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CW'(CLR_CYCLES - 1)) state_d = S_LOAD;
                    else clr_cnt_d = clr_cnt_q + 1'b1;
                end
                S_LOAD: if (rr_in_valid) begin
                    // an out-of-range byte is consumed but never reaches the core
                    if (rr_ok) begin
                        sh_d      = rr_in_data;
                        bit_idx_d = 3'd7;
                        state_d   = S_SHIFT;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
                S_SHIFT: begin
                    sh_d      = {sh_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q - 3'd1;
                    if (bit_idx_q == 3'd0) begin
                        rr_sent_d = rr_sent_q + 1'b1;
                        if (rr_sent_q == NW'(RR_COUNT - 1)) begin
                            timer_d = '0;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    // done takes priority over a timeout landing in the same cycle
                    if (core_done) begin
                        result_d       = core_rmssd;
                        result_valid_d = 1'b1;
                        state_d        = S_IDLE;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        core_rst_n_d = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            clr_cnt_q      <= '0;
            timer_q        <= '0;
            rr_sent_q      <= '0;
            sh_q           <= '0;
            bit_idx_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            range_err_q    <= 1'b0;
            core_rst_n_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            timer_q        <= timer_d;
            rr_sent_q      <= rr_sent_d;
            sh_q           <= sh_d;
            bit_idx_q      <= bit_idx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_timeout_q  <= err_timeout_d;
            range_err_q    <= range_err_d;
            core_rst_n_q   <= core_rst_n_d;
        end
    end

    assign rr_in_ready    = (state_q == S_LOAD);
    assign core_bit_valid = (state_q == S_SHIFT);
    assign core_bit       = core_bit_valid & sh_q[7];
    assign core_rr_valid  = core_bit_valid && (bit_idx_q == 3'd0);
    assign core_rst_n     = core_rst_n_q;
    assign result         = result_q;
    assign result_valid   = result_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign err_timeout    = err_timeout_q;
endmodule

// File: tb/tb_rmssd_seq_ctrl.sv
// Bench for rmssd_seq_ctrl: behavioural core stub, byte-stream scoreboard and directed measurements.
module tb_rmssd_seq_ctrl;
    localparam int RR = 8;

    logic       clk, rst_n, start, abort, rr_in_valid, rr_in_ready;
    logic [7:0] rr_in_data;
    logic       core_rst_n, core_bit, core_bit_valid, core_rr_valid;
    logic [7:0] core_rmssd = 8'd0;
    logic       core_done = 1'b0;
    logic [7:0] result;
    logic       result_valid, busy, err_timeout, rr_range_err;

    int n_chk = 0, n_fail = 0, n_pulse = 0;
    int done_lat = 3;
    logic [7:0] src_q[$];

    rmssd_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rr_in_valid(rr_in_valid), .rr_in_data(rr_in_data), .rr_in_ready(rr_in_ready),
        .core_rst_n(core_rst_n), .core_bit(core_bit), .core_bit_valid(core_bit_valid),
        .core_rr_valid(core_rr_valid), .core_rmssd(core_rmssd), .core_done(core_done),
        .result(result), .result_valid(result_valid), .busy(busy),
        .err_timeout(err_timeout), .rr_range_err(rr_range_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // RMSSD as integer sqrt of the mean squared successive difference, saturated to 8 bits
    function automatic logic [7:0] rmssd_f(input logic [7:0] b [RR]);
        int s = 0, m, r = 0, d;
        for (int i = 1; i < RR; i++) begin
            d = int'(b[i]) - int'(b[i-1]);
            s += d * d;
        end
        m = s / (RR - 1);
        while ((r + 1) * (r + 1) <= m) r++;
        return (r > 255) ? 8'hFF : r[7:0];
    endfunction

    // Core stub: rebuilds bytes from the serial stream, raises done done_lat cycles into WAIT_DONE
    logic [7:0] stub_sh = 8'd0;
    logic [7:0] stub_b [RR];
    int         stub_n = 0, stub_w = 0;
    logic       stub_armed = 1'b0;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            stub_n <= 0; stub_w <= 0; stub_armed <= 1'b0; core_done <= 1'b0; core_rmssd <= 8'd0;
        end else begin
            if (core_bit_valid) stub_sh <= {stub_sh[6:0], core_bit};
            if (core_rr_valid && stub_n < RR) begin
                stub_b[stub_n] <= {stub_sh[6:0], core_bit};
                stub_n <= stub_n + 1;
                if (stub_n == RR - 1) begin stub_armed <= 1'b1; stub_w <= 0; end
            end else if (stub_armed && !core_done && done_lat > 0) begin
                stub_w <= stub_w + 1;
                if (stub_w + 1 == done_lat) core_done <= 1'b1;
            end
            if (stub_n == RR) core_rmssd <= rmssd_f(stub_b);
        end
    end

    // Scoreboard: every accepted byte must appear as 8 consecutive MSB-first bits
    logic [7:0] mq[$];
    logic [7:0] meas[$];
    logic [7:0] arr [RR];
    logic [7:0] first_bits = 8'd0, first_rrv = 8'd0;
    int pos = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete(); meas.delete(); pos = 0;
        end else begin
            if (core_bit_valid) begin
                if (mq.size() == 0) chk("bit_without_byte", 0, 1);
                else begin
                    chk("core_bit", core_bit, mq[0][7-pos]);
                    chk("core_rr_valid", core_rr_valid, pos == 7);
                    if (meas.size() == 0) begin
                        first_bits = {first_bits[6:0], core_bit};
                        first_rrv  = {first_rrv[6:0], core_rr_valid};
                    end
                    pos++;
                    if (pos == 8) begin meas.push_back(mq.pop_front()); pos = 0; end
                end
            end else begin
                chk("rr_valid_idle", core_rr_valid, 0);
            end
            if (rr_in_ready) chk("ready_vs_shift", core_bit_valid, 0);
            if (rr_in_valid && rr_in_ready) begin
`ifdef RMSSD_RANGE_CHECK_EN
                if (rr_in_data >= 8'd20 && rr_in_data <= 8'd250) mq.push_back(rr_in_data);
`else
                mq.push_back(rr_in_data);
`endif
            end
            if (result_valid) begin
                n_pulse++;
                if (meas.size() == RR) begin
                    for (int i = 0; i < RR; i++) arr[i] = meas[i];
                    chk("result_model", result, rmssd_f(arr));
                end else chk("result_bytes", meas.size(), RR);
            end
            if (!busy) begin mq.delete(); meas.delete(); pos = 0; end
        end
    end

    task automatic set_alt(input logic [7:0] a, input logic [7:0] b);
        src_q.delete();
        for (int i = 0; i < RR; i++) src_q.push_back((i % 2 == 0) ? a : b);
    endtask

    // Drives one measurement from src_q; returns cycles spent in CLEAR, LOAD/SHIFT and WAIT_DONE
    task automatic run_meas(input int gap_after, input int abort_at, input bit abort_on_done,
                            output int clr_c, output int ls_c, output int wt_c);
        int idx = 0, bits = 0, stall = 0, cyc = 0;
        bit gap_active = 0, hs, do_abort = 0, post_abort = 0;
        clr_c = 0; ls_c = 0; wt_c = 0;
        rr_in_data = src_q[0]; rr_in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < 2000) begin
            @(negedge clk); cyc++;
            if (post_abort) begin
                chk("abort_busy", busy, 0);
                chk("abort_core_rst_n", core_rst_n, 0);
            end
            if (!busy) break;
            if (!core_rst_n) clr_c++;
            else if (rr_in_ready || core_bit_valid) ls_c++;
            else wt_c++;
            hs = rr_in_valid && rr_in_ready;
            if (gap_active) begin
                if (stall > 0) chk("gap_ready", rr_in_ready, 1);
                if (rr_in_ready) begin
                    chk("gap_strobes", {core_bit_valid, core_rr_valid}, 0);
                    stall++;
                end
            end
            if (core_bit_valid) begin
                if (bits == abort_at) do_abort = 1;
                if (bits == 20) start = 1'b1;
                bits++;
            end
            if (abort_on_done && core_done) do_abort = 1;
            if (do_abort) abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0;
            if (do_abort) begin do_abort = 0; post_abort = 1; end
            if (hs) begin
                idx++;
                if (idx - 1 == gap_after) begin gap_active = 1; rr_in_valid = 1'b0; end
                if (idx < src_q.size()) rr_in_data = src_q[idx];
                else rr_in_valid = 1'b0;
            end
            if (gap_active && stall == 5) begin
                gap_active = 0; stall = 0;
                rr_in_valid = (idx < src_q.size());
            end
        end
        if (cyc >= 2000) chk("meas_cycle_budget", 0, 1);
        rr_in_valid = 1'b0;
    endtask

    initial begin
        int c, l, w, p0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rr_in_valid = 1'b0; rr_in_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_range_err", rr_range_err, 0);
        chk("rst_ready", rr_in_ready, 0);
        chk("rst_bit_valid", core_bit_valid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8 x 100 back to back
        set_alt(8'd100, 8'd100); p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t1_clear_cycles", c, 2);
        chk("t1_load_shift_cycles", l, 72);
        chk("t1_wait_cycles", w, 4);
        chk("t1_pulses", n_pulse - p0, 1);
        chk("t1_result", result, 0);
        chk("t1_err_timeout", err_timeout, 0);

        // 0xA5 first: bit pattern and rr_valid position
        set_alt(8'd100, 8'd100); src_q[0] = 8'hA5; p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t2_first_bits", first_bits, 8'hA5);
        chk("t2_first_rr_valid", first_rrv, 8'h01);
        chk("t2_pulses", n_pulse - p0, 1);
        chk("t2_result", result, 24);

        // source stalls 5 cycles between bytes 3 and 4
        set_alt(8'd100, 8'd110); p0 = n_pulse;
        run_meas(2, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t3_load_shift_cycles", l, 77);
        chk("t3_pulses", n_pulse - p0, 1);
        chk("t3_result", result, 10);

        // done never arrives
        done_lat = -1; set_alt(8'd100, 8'd130); p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t4_wait_cycles", w, 64);
        chk("t4_err_timeout", err_timeout, 1);
        chk("t4_pulses", n_pulse - p0, 0);
        chk("t4_result_held", result, 10);

        // done lands on the final timeout cycle
        done_lat = 63; p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t5_wait_cycles", w, 64);
        chk("t5_err_timeout", err_timeout, 0);
        chk("t5_pulses", n_pulse - p0, 1);
        chk("t5_result", result, 30);
        done_lat = 3;

        // abort during bit 3 of byte 2, then a clean run
        set_alt(8'd100, 8'd100); p0 = n_pulse;
        run_meas(-1, 12, 0, c, l, w); repeat (3) @(negedge clk);
        chk("t6_pulses", n_pulse - p0, 0);
        chk("t6_err_timeout", err_timeout, 0);
        chk("t6_result_held", result, 30);
        set_alt(8'd120, 8'd100); p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t6_restart_pulses", n_pulse - p0, 1);
        chk("t6_restart_result", result, 20);

        // abort and done in the same cycle
        set_alt(8'd100, 8'd100); p0 = n_pulse;
        run_meas(-1, -1, 1, c, l, w); repeat (3) @(negedge clk);
        chk("t7_pulses", n_pulse - p0, 0);
        chk("t7_result_held", result, 20);

`ifdef RMSSD_RANGE_CHECK_EN
        src_q = {8'd100, 8'd110, 8'd100, 8'd110, 8'd10, 8'd100, 8'd110, 8'd100, 8'd110};
        p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t9_load_shift_cycles", l, 73);
        chk("t9_range_err", rr_range_err, 1);
        chk("t9_pulses", n_pulse - p0, 1);
        chk("t9_result", result, 10);
`else
        src_q = {8'd100, 8'd110, 8'd100, 8'd110, 8'd10, 8'd100, 8'd110, 8'd100};
        p0 = n_pulse;
        run_meas(-1, -1, 0, c, l, w); repeat (2) @(negedge clk);
        chk("t9_load_shift_cycles", l, 72);
        chk("t9_range_err", rr_range_err, 0);
        chk("t9_pulses", n_pulse - p0, 1);
        chk("t9_result", result, 51);
`endif

        // asynchronous reset in the middle of a measurement
        rr_in_data = 8'd100; rr_in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t8_busy_before", busy, 1);
        chk("t8_result_before", result, 51 - ((result == 8'd10) ? 41 : 0));
        #2 rst_n = 1'b0;
        #1;
        chk("t8_core_rst_n", core_rst_n, 0);
        chk("t8_result", result, 0);
        chk("t8_result_valid", result_valid, 0);
        chk("t8_busy", busy, 0);
        chk("t8_err_timeout", err_timeout, 0);
        chk("t8_bit_valid", core_bit_valid, 0);
        chk("t8_ready", rr_in_ready, 0);
        rr_in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t8_idle_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
